boot_load_sequencer: RTL and testbench
======================================

// Module: boot_load_sequencer
// PURPOSE
//  Sequences the boot-load port of the 16x8 program/data memory. Accepts a byte stream from the HPS over a valid/ready
//  handshake, drives BootLoad/BootLoadAddress/WriteToMemory to write words 0..LOAD_WORDS-1, then releases the CPU.
//  Sits between the HPS bridge and Memory; the only driver of Memory's BootLoad, BootLoadAddress and WriteToMemory.
// PARAMETERS
//  LOAD_WORDS  8  program words written per boot, addresses 0..LOAD_WORDS-1 (1..16)
//  ADDR_W      4  memory address width
//  DATA_W      8  memory word width
// PORTS
//  clk             in   1       system clock, all state on posedge
//  reset           in   1       asynchronous, active-high reset
//  start           in   1       one-cycle request to (re)load memory
//  hps_data        in   DATA_W  byte from HPS
//  hps_valid       in   1       hps_data valid
//  hps_ready       out  1       sequencer accepts hps_data this cycle
//  mem_boot_load   out  1       to Memory BootLoad
//  mem_boot_addr   out  ADDR_W  to Memory BootLoadAddress
//  mem_write_data  out  DATA_W  to Memory WriteToMemory
//  cpu_run         out  1       CPU may execute; low while loading
//  busy            out  1       high in LOAD/DRAIN/CHECK
//  boot_error      out  1       checksum mismatch (only with BOOT_CHECKSUM_EN)
//  words_loaded    out  5       count of data words accepted in current/last load
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE; all outputs 0 (hps_ready, mem_boot_load, addr, data, cpu_run, busy,
//    boot_error, words_loaded). Reset mid-LOAD drops mem_boot_load at once; partial memory contents not restored.
//  - All outputs registered. Handshake: transfer when hps_valid && hps_ready at a posedge; hps_data may change freely
//    when no transfer. hps_ready high only in LOAD.
//  - IDLE: wait. start=1 -> LOAD; words_loaded<=0, mem_boot_addr<=0, boot_error<=0, mem_boot_load<=1, busy<=1.
//  - LOAD: mem_boot_load=1, cpu_run=0. On transfer k (k=0..LOAD_WORDS-1): mem_write_data<=hps_data,
//    mem_boot_addr<=k, words_loaded<=k+1. Memory commits the word on the following posedge (write latency 1 cycle
//    after transfer). While idle between transfers, addr/data hold; Memory's repeated rewrite is idempotent.
//    After transfer LOAD_WORDS-1 -> DRAIN; hps_ready deasserts same edge.
//  - DRAIN: one cycle, mem_boot_load held 1 so last word commits. -> CHECK (macro) else RUN.
//  - RUN: mem_boot_load=0, cpu_run=1, busy=0. start=1 -> LOAD (reload; cpu_run<=0 same edge).
//  - start ignored in LOAD/DRAIN/CHECK. hps_valid ignored outside LOAD. Address never wraps: counter stops at LOAD_WORDS.
//  - Simultaneous start and transfer in IDLE/RUN: no transfer (hps_ready was 0); LOAD entered.
//  - Memory addresses LOAD_WORDS..15 are not driven; Memory itself clears 8..15 while BootLoad is high.
// CONFIGURATION
//  BOOT_CHECKSUM_EN defined: LOAD accepts LOAD_WORDS+1 bytes; final byte is checksum, not written (addr/data hold
//    last word). Running 8-bit sum (mod 256) of data bytes compared in CHECK (one cycle, mem_boot_load=1):
//    match -> RUN; mismatch -> ERROR: boot_error=1, cpu_run=0, mem_boot_load=0, busy=0; start -> LOAD clears it.
//    words_loaded counts data bytes only.
//  Not defined: no CHECK/ERROR states, boot_error tied 0, exactly LOAD_WORDS bytes accepted.
// TESTING
//  1. Reset, start, stream 0x11..0x18 back-to-back -> addr 0..7 written, words_loaded=8, cpu_run=1 two cycles
//     after last transfer (DRAIN then RUN); Memory[0..7]=0x11..0x18.
//  2. Same stream with hps_valid low every other cycle -> identical memory image; hps_ready stays 1 during gaps.
//  3. Assert reset after 3rd transfer -> mem_boot_load=0 and hps_ready=0 asynchronously; new start reloads from addr 0.
//  4. In RUN, pulse start, load 0xA0..0xA7 -> cpu_run low next edge, memory holds new image, cpu_run returns to 1.
//  5. BOOT_CHECKSUM_EN: bytes 0x01..0x08 + 0x24 -> RUN, boot_error=0; checksum 0x25 -> ERROR, boot_error=1,
//     cpu_run=0; start clears boot_error.
//  6. start held high through entire LOAD -> no restart; words_loaded increments monotonically to 8.

Source files
------------

// File: rtl/boot_load_sequencer.sv
// ---------------------------------------------------------------------------
// boot_load_sequencer
//
// Purpose:
//   Loads the program/data memory through its boot-load port. A byte stream
//   from the HPS bridge arrives over a valid/ready handshake. Each byte is
//   written to the next memory word, starting at address 0 and ending at
//   LOAD_WORDS-1. The sequencer then releases the CPU. It is the only driver
//   of the memory's BootLoad, BootLoadAddress and WriteToMemory inputs.
//
// Optional feature (macro BOOT_CHECKSUM_EN):
//   One extra byte follows the data. That byte is an 8-bit modulo-256
//   checksum of the data bytes. A mismatch parks the sequencer in ERROR with
//   boot_error set. With the macro undefined, exactly LOAD_WORDS bytes are
//   accepted and boot_error is tied to 0.
//
// Ports:
//   clk            system clock; all state changes on posedge
//   reset          asynchronous, active-high
//   start          one-cycle request to (re)load memory
//                  (taken only in IDLE/RUN/ERROR)
//   hps_data       byte from the HPS
//   hps_valid      hps_data is valid
//   hps_ready      sequencer accepts hps_data this cycle (high only in LOAD)
//   mem_boot_load  memory BootLoad
//   mem_boot_addr  memory BootLoadAddress
//   mem_write_data memory WriteToMemory
//   cpu_run        CPU may execute
//   busy           high in LOAD/DRAIN/CHECK
//   boot_error     checksum mismatch (checksum build only)
//   words_loaded   data words accepted in the current or last load
//
// Handshake:
//   A byte transfers on a posedge where hps_valid && hps_ready. When no
//   transfer happens, hps_data may change freely.
//
// All outputs come straight from registers. Each register is loaded with the
// value that matches the state being entered.
// ---------------------------------------------------------------------------
module boot_load_sequencer #(
    parameter int LOAD_WORDS = 8,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] hps_data,
    input  logic              hps_valid,
    output logic              hps_ready,
    output logic              mem_boot_load,
    output logic [ADDR_W-1:0] mem_boot_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              cpu_run,
    output logic              busy,
    output logic              boot_error,
    output logic [4:0]        words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_CHECK = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [4:0] LAST_WORD = 5'(LOAD_WORDS - 1);
    localparam logic [4:0] ALL_WORDS = 5'(LOAD_WORDS);

    state_t state_q, state_d;

    logic              ready_q, ready_d;
    logic              boot_load_q, boot_load_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              error_d;

    // ready_q is high exactly when state_q is LOAD.
    logic xfer;
    // The count stops at LOAD_WORDS, so the address never wraps.
    logic data_phase;
    assign xfer       = ready_q && hps_valid;
    assign data_phase = (cnt_q < ALL_WORDS);

`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              sum_ok_q, sum_ok_d;
    logic              error_q;
`endif

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            boot_load_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum_q       <= '0;
            sum_ok_q    <= 1'b0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            boot_load_q <= boot_load_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            run_q       <= run_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q       <= sum_d;
            sum_ok_q    <= sum_ok_d;
            error_q     <= error_d;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
`ifdef BOOT_CHECKSUM_EN
            // The checksum byte arrives after the last data word.
            S_LOAD: if (xfer && !data_phase) state_d = S_DRAIN;
            S_DRAIN: state_d = S_CHECK;
            S_CHECK: state_d = sum_ok_q ? S_RUN : S_ERROR;
            S_ERROR: if (start) state_d = S_LOAD;
`else
            S_LOAD: if (xfer && cnt_q == LAST_WORD) state_d = S_DRAIN;
            S_DRAIN: state_d = S_RUN;
`endif
            S_RUN: if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output logic: next values for the output registers
    // ---------------------------------------------------------------------
    always_comb begin
        ready_d     = (state_d == S_LOAD);
        boot_load_d = (state_d == S_LOAD) || (state_d == S_DRAIN) ||
                      (state_d == S_CHECK);
        busy_d      = boot_load_d;
        run_d       = (state_d == S_RUN);
`ifdef BOOT_CHECKSUM_EN
        error_d     = (state_d == S_ERROR);
`else
        error_d     = 1'b0;
`endif
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
`ifdef BOOT_CHECKSUM_EN
        sum_d       = sum_q;
        sum_ok_d    = sum_ok_q;
`endif
        if (state_q != S_LOAD && state_d == S_LOAD) begin
            // Fresh load: restart at word 0.
            // data_q keeps its value; the first transfer overwrites word 0.
            addr_d = '0;
            cnt_d  = '0;
`ifdef BOOT_CHECKSUM_EN
            sum_d  = '0;
`endif
        end else if (xfer && data_phase) begin
            addr_d = ADDR_W'(cnt_q);
            data_d = hps_data;
            cnt_d  = cnt_q + 5'd1;
`ifdef BOOT_CHECKSUM_EN
            sum_d  = sum_q + hps_data;
`endif
        end
`ifdef BOOT_CHECKSUM_EN
        else if (xfer) begin
            // The checksum byte: address and data keep the last word.
            sum_ok_d = (sum_q == hps_data);
        end
`endif
    end

    assign hps_ready      = ready_q;
    assign mem_boot_load  = boot_load_q;
    assign mem_boot_addr  = addr_q;
    assign mem_write_data = data_q;
    assign cpu_run        = run_q;
    assign busy           = busy_q;
    assign words_loaded   = cnt_q;
`ifdef BOOT_CHECKSUM_EN
    assign boot_error     = error_q;
`else
    assign boot_error     = error_d;
`endif

endmodule

// File: tb/tb_boot_load_sequencer.sv
module tb_boot_load_sequencer;

    localparam int LW = 8;
`ifdef BOOT_CHECKSUM_EN
    localparam int SETTLE = 3;  // DRAIN, CHECK, then RUN/ERROR
    localparam int NBYTES = LW + 1;
`else
    localparam int SETTLE = 2;  // DRAIN, then RUN
    localparam int NBYTES = LW;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] hps_data;
    logic       hps_valid;
    logic       hps_ready;
    logic       mem_boot_load;
    logic [3:0] mem_boot_addr;
    logic [7:0] mem_write_data;
    logic       cpu_run;
    logic       busy;
    logic       boot_error;
    logic [4:0] words_loaded;

    int checks = 0;
    int failures = 0;

    logic [7:0] img [LW];      // image the HPS streams in
    logic [7:0] mem_img [16];  // behavioural memory: write commits on posedge

    boot_load_sequencer #(.LOAD_WORDS(LW), .ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .hps_data(hps_data), .hps_valid(hps_valid), .hps_ready(hps_ready),
        .mem_boot_load(mem_boot_load), .mem_boot_addr(mem_boot_addr),
        .mem_write_data(mem_write_data), .cpu_run(cpu_run), .busy(busy),
        .boot_error(boot_error), .words_loaded(words_loaded)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_boot_load) mem_img[mem_boot_addr] <= mem_write_data;

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; hps_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one complete load of img[]. All driving and sampling is done on
    // negedges. gap_mode -1 forces exactly one idle cycle before each byte;
    // otherwise each gap is random in 0..gap_mode.
    task automatic do_load(input string tag, input int gap_mode,
                           input bit hold_start, input bit bad_sum);
        logic [7:0] sum;
        logic [7:0] b;
        int gap;
        int exp_cnt;
        sum = 8'd0;
        for (int i = 0; i < LW; i++) sum = sum + img[i];
        @(negedge clk);
        start = 1'b1; hps_valid = 1'b0;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        checks++; if (hps_ready !== 1'b1 || busy !== 1'b1 || mem_boot_load !== 1'b1 || cpu_run !== 1'b0) begin
            failures++; $display("FAIL %s load_entry: ready=%b busy=%b boot_load=%b cpu_run=%b required 1 1 1 0", tag, hps_ready, busy, mem_boot_load, cpu_run); end
        checks++; if (words_loaded !== 5'd0 || mem_boot_addr !== 4'd0 || boot_error !== 1'b0) begin
            failures++; $display("FAIL %s load_clear: words=%0d addr=%0d err=%b required 0 0 0", tag, words_loaded, mem_boot_addr, boot_error); end
        for (int k = 0; k < NBYTES; k++) begin
            b = (k < LW) ? img[k] : (bad_sum ? sum + 8'd1 : sum);
            gap = (gap_mode < 0) ? 1 : int'($urandom_range(0, gap_mode));
            exp_cnt = (k < LW) ? k : LW;
            for (int g = 0; g < gap; g++) begin
                hps_valid = 1'b0; hps_data = 8'($urandom);
                @(negedge clk);
                checks++; if (hps_ready !== 1'b1 || words_loaded !== 5'(exp_cnt)) begin
                    failures++; $display("FAIL %s gap k=%0d: ready=%b words=%0d required 1 %0d", tag, k, hps_ready, words_loaded, exp_cnt); end
            end
            hps_valid = 1'b1; hps_data = b;
            @(negedge clk);
            exp_cnt = (k < LW) ? k + 1 : LW;
            checks++; if (words_loaded !== 5'(exp_cnt)) begin
                failures++; $display("FAIL %s words k=%0d: got %0d required %0d", tag, k, words_loaded, exp_cnt); end
            if (k < LW) begin
                checks++; if (mem_boot_addr !== 4'(k) || mem_write_data !== b) begin
                    failures++; $display("FAIL %s write k=%0d: addr=%0d data=%h required %0d %h", tag, k, mem_boot_addr, mem_write_data, k, b); end
            end else begin
                checks++; if (mem_boot_addr !== 4'(LW - 1) || mem_write_data !== img[LW-1]) begin
                    failures++; $display("FAIL %s cksum_hold: addr=%0d data=%h required %0d %h", tag, mem_boot_addr, mem_write_data, LW - 1, img[LW-1]); end
            end
        end
        hps_valid = 1'b0; start = 1'b0;
        // In DRAIN now.
        checks++; if (hps_ready !== 1'b0 || mem_boot_load !== 1'b1 || cpu_run !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL %s drain: ready=%b boot_load=%b cpu_run=%b busy=%b required 0 1 0 1", tag, hps_ready, mem_boot_load, cpu_run, busy); end
        repeat (SETTLE - 1) @(negedge clk);
        checks++; if (cpu_run !== !bad_sum || boot_error !== bad_sum || busy !== 1'b0 || mem_boot_load !== 1'b0) begin
            failures++; $display("FAIL %s finish: cpu_run=%b err=%b busy=%b boot_load=%b required %b %b 0 0", tag, cpu_run, boot_error, busy, mem_boot_load, !bad_sum, bad_sum); end
        for (int i = 0; i < LW; i++) begin
            checks++; if (mem_img[i] !== img[i]) begin
                failures++; $display("FAIL %s mem[%0d]: got %h required %h", tag, i, mem_img[i], img[i]); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; hps_valid = 1'b1; hps_data = 8'h5A;
        repeat (2) @(negedge clk);
        checks++; if ({hps_ready, mem_boot_load, mem_boot_addr, mem_write_data, cpu_run, busy, boot_error, words_loaded} !== '0) begin
            failures++; $display("FAIL reset_values: ready=%b bl=%b addr=%h data=%h run=%b busy=%b err=%b words=%0d required all 0",
                hps_ready, mem_boot_load, mem_boot_addr, mem_write_data, cpu_run, busy, boot_error, words_loaded); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (hps_ready !== 1'b0 || words_loaded !== 5'd0 || mem_boot_load !== 1'b0) begin
            failures++; $display("FAIL idle_ignores_valid: ready=%b words=%0d bl=%b required 0 0 0", hps_ready, words_loaded, mem_boot_load); end
        hps_valid = 1'b0;
    endtask

    task automatic test_basic_stream();
        for (int i = 0; i < LW; i++) img[i] = 8'(8'h11 + i);
        do_load("basic", 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < LW; i++) img[i] = 8'(8'h31 + i);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            hps_valid = 1'b1; hps_data = 8'($urandom);
            @(negedge clk);
        end
        hps_valid = 1'b0;
        checks++; if (words_loaded !== 5'd3) begin
            failures++; $display("FAIL midload_count: got %0d required 3", words_loaded); end
        reset = 1'b1;
        #1;
        checks++; if (mem_boot_load !== 1'b0 || hps_ready !== 1'b0 || busy !== 1'b0 || words_loaded !== 5'd0) begin
            failures++; $display("FAIL async_reset: bl=%b ready=%b busy=%b words=%0d required 0 0 0 0", mem_boot_load, hps_ready, busy, words_loaded); end
        @(negedge clk);
        reset = 1'b0;
        do_load("after_reset", 1, 1'b0, 1'b0);
    endtask

    task automatic test_gapped_stream();
        for (int i = 0; i < LW; i++) img[i] = 8'(8'h11 + i);
        do_load("gapped", -1, 1'b0, 1'b0);
    endtask

    task automatic test_reload_in_run();
        for (int i = 0; i < LW; i++) img[i] = 8'(8'hA0 + i);
        checks++; if (cpu_run !== 1'b1) begin
            failures++; $display("FAIL reload_pre_run: cpu_run=%b required 1", cpu_run); end
        do_load("reload", 2, 1'b0, 1'b0);
    endtask

    task automatic test_start_held();
        for (int i = 0; i < LW; i++) img[i] = 8'($urandom);
        do_load("start_held", 2, 1'b1, 1'b0);
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        for (int i = 0; i < LW; i++) img[i] = 8'(8'h01 + i);
        do_load("cksum_good", 0, 1'b0, 1'b0);
        do_load("cksum_bad", 1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++; if (boot_error !== 1'b1 || cpu_run !== 1'b0) begin
            failures++; $display("FAIL error_sticky: err=%b run=%b required 1 0", boot_error, cpu_run); end
        do_load("cksum_clear", 0, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_valid_outside_load();
        hps_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hps_data = 8'($urandom);
            @(negedge clk);
            checks++; if (hps_ready !== 1'b0 || words_loaded !== 5'(LW) || mem_boot_load !== 1'b0 || cpu_run !== 1'b1) begin
                failures++; $display("FAIL run_ignores_valid: ready=%b words=%0d bl=%b run=%b required 0 %0d 0 1", hps_ready, words_loaded, mem_boot_load, cpu_run, LW); end
        end
        hps_valid = 1'b0;
    endtask

    task automatic test_start_with_valid();
        apply_reset();
        @(negedge clk);
        start = 1'b1; hps_valid = 1'b1; hps_data = 8'h5A;
        @(negedge clk);
        start = 1'b0; hps_valid = 1'b0;
        checks++; if (words_loaded !== 5'd0 || hps_ready !== 1'b1 || cpu_run !== 1'b0) begin
            failures++; $display("FAIL start_with_valid: words=%0d ready=%b run=%b required 0 1 0", words_loaded, hps_ready, cpu_run); end
        apply_reset();
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < LW; i++) img[i] = 8'($urandom);
            do_load("random", 3, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        start = 1'b0; hps_valid = 1'b0; hps_data = 8'h00; reset = 1'b1;
        test_reset();
        test_basic_stream();
        test_reset_mid_load();
        test_gapped_stream();
        test_reload_in_run();
        test_start_held();
        test_valid_outside_load();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        test_start_with_valid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
